control_unit_p: RTL and testbench

//  Parametrised multi-cycle controller for the processor.

---
 rtl/control_unit_p_if.sv | 40 ++++
 rtl/control_unit_p.sv | 155 +++++++++++++++
 tb/tb_control_unit_p.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_p_if.sv
// Controller-to-datapath/instruction-memory bundle: fetch inputs, status flag and all decoded controls.
interface control_unit_p_if #(
    parameter int unsigned PC_W      = 7,
    parameter int unsigned RF_ADDR_W = 4,
    parameter int unsigned D_ADDR_W  = 8,
    parameter int unsigned ALU_SEL_W = 3
);
    localparam int unsigned IW = 4 + 3 * RF_ADDR_W;

    logic                   run;
    logic [IW-1:0]          inst_data;
    logic                   rf_ra_zero;
    logic [PC_W-1:0]        pc_out;
    logic [IW-1:0]          ir_out;
    logic [3:0]             state;
    logic [3:0]             next_state;
    logic [D_ADDR_W-1:0]    d_addr;
    logic                   d_wr;
    logic [1:0]             rf_s;
    logic [2*RF_ADDR_W-1:0] rf_w_const;
    logic                   rf_w_en;
    logic [RF_ADDR_W-1:0]   rf_w_addr;
    logic [RF_ADDR_W-1:0]   rf_ra_addr;
    logic [RF_ADDR_W-1:0]   rf_rb_addr;
    logic [ALU_SEL_W-1:0]   alu_s0;
    logic                   halted;
    logic                   illegal;

    modport master (
        input  run, inst_data, rf_ra_zero,
        output pc_out, ir_out, state, next_state, d_addr, d_wr, rf_s, rf_w_const,
               rf_w_en, rf_w_addr, rf_ra_addr, rf_rb_addr, alu_s0, halted, illegal
    );

    modport slave (
        output run, inst_data, rf_ra_zero,
        input  pc_out, ir_out, state, next_state, d_addr, d_wr, rf_s, rf_w_const,
               rf_w_en, rf_w_addr, rf_ra_addr, rf_rb_addr, alu_s0, halted, illegal
    );
endinterface

// File: rtl/control_unit_p.sv
// Multi-cycle processor controller: PC/IR, fetch with run stall, decode, LDC, JMPZ and illegal-opcode trap.
module control_unit_p #(
    parameter int unsigned PC_W      = 7,
    parameter int unsigned RF_ADDR_W = 4,
    parameter int unsigned D_ADDR_W  = 8,
    parameter int unsigned ALU_SEL_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    control_unit_p_if.master bus
);
    localparam int unsigned R  = RF_ADDR_W;
    localparam int unsigned IW = 4 + 3 * R;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2, S_LOAD_A = 4'd3,
        S_LOAD_B = 4'd4,  S_STORE  = 4'd5,  S_ADD    = 4'd6, S_SUB    = 4'd7,
        S_HALT   = 4'd8,  S_LDC    = 4'd9,  S_JMPZ   = 4'd10, S_JWAIT = 4'd11
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic            illegal_q, illegal_d;

    logic [D_ADDR_W-1:0]  d_addr_c;
    logic                 d_wr_c;
    logic [1:0]           rf_s_c;
    logic [2*R-1:0]       rf_w_const_c;
    logic                 rf_w_en_c;
    logic [R-1:0]         rf_w_addr_c, rf_ra_addr_c, rf_rb_addr_c;
    logic [ALU_SEL_W-1:0] alu_s0_c;
    logic                 halted_c;

    logic [3:0]     op;
    logic [R-1:0]   fld_a, fld_b, fld_c;
    logic [2*R-1:0] imm;

    assign op    = ir_q[IW-1 -: 4];
    assign fld_a = ir_q[3*R-1 -: R];
    assign fld_b = ir_q[2*R-1 -: R];
    assign fld_c = ir_q[R-1:0];
    assign imm   = ir_q[2*R-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_INIT;
            pc_q      <= '0;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        illegal_d    = illegal_q;
        d_addr_c     = '0;
        d_wr_c       = 1'b0;
        rf_s_c       = 2'd0;
        rf_w_const_c = '0;
        rf_w_en_c    = 1'b0;
        rf_w_addr_c  = '0;
        rf_ra_addr_c = '0;
        rf_rb_addr_c = '0;
        alu_s0_c     = '0;
        halted_c     = 1'b0;
        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.run) begin
                    ir_d    = bus.inst_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    4'd0:    state_d = S_FETCH;
                    4'd1:    state_d = S_STORE;
                    4'd2:    state_d = S_LOAD_A;
                    4'd3:    state_d = S_ADD;
                    4'd4:    state_d = S_SUB;
                    4'd5:    state_d = S_HALT;
                    4'd6:    state_d = S_LDC;
                    4'd7:    state_d = S_JMPZ;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_STORE: begin
                d_addr_c     = imm[D_ADDR_W-1:0];
                rf_ra_addr_c = fld_a;
                d_wr_c       = 1'b1;
                state_d      = S_FETCH;
            end
            S_LOAD_A, S_LOAD_B: begin
                d_addr_c    = imm[D_ADDR_W-1:0];
                rf_s_c      = 2'd1;
                rf_w_addr_c = fld_a;
                rf_w_en_c   = (state_q == S_LOAD_B);
                state_d     = (state_q == S_LOAD_A) ? S_LOAD_B : S_FETCH;
            end
            S_ADD, S_SUB: begin
                rf_ra_addr_c = fld_a;
                rf_rb_addr_c = fld_b;
                rf_w_addr_c  = fld_c;
                alu_s0_c     = (state_q == S_ADD) ? ALU_SEL_W'(1) : ALU_SEL_W'(2);
                rf_w_en_c    = 1'b1;
                state_d      = S_FETCH;
            end
            S_LDC: begin
                rf_w_addr_c  = fld_a;
                rf_s_c       = 2'd2;
                rf_w_const_c = imm;
                rf_w_en_c    = 1'b1;
                state_d      = S_FETCH;
            end
            S_JMPZ: begin
                rf_ra_addr_c = fld_a;
                if (bus.rf_ra_zero) pc_d = imm[PC_W-1:0];
                state_d = S_JWAIT;
            end
            // one idle cycle so instruction memory sees the loaded PC before FETCH
            S_JWAIT: state_d = S_FETCH;
            S_HALT:  halted_c = 1'b1;
            default: state_d = S_INIT;
        endcase
    end

    // controls are gated combinationally so nothing is written during a reset cycle
    assign bus.pc_out     = pc_q;
    assign bus.ir_out     = ir_q;
    assign bus.state      = state_q;
    assign bus.illegal    = illegal_q;
    assign bus.next_state = reset ? S_INIT : state_d;
    assign bus.d_addr     = reset ? '0 : d_addr_c;
    assign bus.d_wr       = reset ? 1'b0 : d_wr_c;
    assign bus.rf_s       = reset ? 2'd0 : rf_s_c;
    assign bus.rf_w_const = reset ? '0 : rf_w_const_c;
    assign bus.rf_w_en    = reset ? 1'b0 : rf_w_en_c;
    assign bus.rf_w_addr  = reset ? '0 : rf_w_addr_c;
    assign bus.rf_ra_addr = reset ? '0 : rf_ra_addr_c;
    assign bus.rf_rb_addr = reset ? '0 : rf_rb_addr_c;
    assign bus.alu_s0     = reset ? '0 : alu_s0_c;
    assign bus.halted     = reset ? 1'b0 : halted_c;
endmodule

// File: tb/tb_control_unit_p.sv
// Bench for control_unit_p: directed programs then random ones, checked against an instruction-level model.
module tb_control_unit_p;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    control_unit_p_if bus ();
    control_unit_p dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [15:0] mem [128];
    always @(posedge clk) bus.inst_data <= mem[bus.pc_out];

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] act;     // 1 jmpz, 2 halt, 3 illegal halt
        logic [7:0] d_addr;
        logic       d_wr;
        logic [1:0] rf_s;
        logic [7:0] cst;
        logic       wen;
        logic [3:0] wa;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
        logic       hlt;
    } exp_t;

    exp_t        q[$];
    logic [6:0]  m_pc;
    logic [15:0] m_ir;
    logic        m_ill, m_halt;

    function automatic exp_t rec(input logic [3:0] st);
        exp_t e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic logic [35:0] ctl(input exp_t e);
        return {e.d_addr, e.d_wr, e.rf_s, e.cst, e.wen, e.wa, e.ra, e.rb, e.alu, e.hlt};
    endfunction

    // Expand one fetched instruction into the cycles it must produce after FETCH.
    function automatic void expand(input logic [15:0] ir);
        exp_t e;
        logic [3:0] op = ir[15:12];
        logic [3:0] a  = ir[11:8];
        logic [3:0] b  = ir[7:4];
        logic [3:0] c  = ir[3:0];
        logic [7:0] im = ir[7:0];
        e = rec(4'd2);
        if (op == 4'd5) e.act = 2'd2;
        if (op >= 4'd8) e.act = 2'd3;
        q.push_back(e);
        case (op)
            4'd1: begin e = rec(4'd5); e.d_addr = im; e.ra = a; e.d_wr = 1'b1; q.push_back(e); end
            4'd2: begin
                e = rec(4'd3); e.d_addr = im; e.rf_s = 2'd1; e.wa = a; q.push_back(e);
                e.st = 4'd4; e.wen = 1'b1; q.push_back(e);
            end
            4'd3, 4'd4: begin
                e = rec(op == 4'd3 ? 4'd6 : 4'd7);
                e.ra = a; e.rb = b; e.wa = c; e.wen = 1'b1;
                e.alu = (op == 4'd3) ? 3'd1 : 3'd2;
                q.push_back(e);
            end
            4'd6: begin
                e = rec(4'd9); e.wa = a; e.rf_s = 2'd2; e.cst = im; e.wen = 1'b1; q.push_back(e);
            end
            4'd7: begin
                e = rec(4'd10); e.ra = a; e.act = 2'd1; q.push_back(e);
                q.push_back(rec(4'd11));
            end
            default: ;
        endcase
    endfunction

    function automatic exp_t peek();
        exp_t e;
        if (q.size() > 0) return q[0];
        if (m_halt) begin
            e = rec(4'd8); e.hlt = 1'b1; return e;
        end
        return rec(4'd1);
    endfunction

    function automatic void step(input logic r, input logic z);
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.act == 2'd1 && z) m_pc = m_ir[6:0];
            if (e.act == 2'd2) m_halt = 1'b1;
            if (e.act == 2'd3) begin m_halt = 1'b1; m_ill = 1'b1; end
        end else if (!m_halt && r) begin
            m_ir = mem[m_pc];
            m_pc = m_pc + 7'd1;
            expand(m_ir);
        end
    endfunction

    function automatic void model_reset();
        m_pc = '0; m_ir = '0; m_ill = 1'b0; m_halt = 1'b0;
        q.delete();
        q.push_back(rec(4'd0));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check this cycle against the model, advance at the edge.
    task automatic cycle(input logic r, input logic z, input logic rs);
        exp_t e;
        logic [35:0] dut_ctl;
        bus.run = r; bus.rf_ra_zero = z; reset = rs;
        #1;
        dut_ctl = {bus.d_addr, bus.d_wr, bus.rf_s, bus.rf_w_const, bus.rf_w_en, bus.rf_w_addr,
                   bus.rf_ra_addr, bus.rf_rb_addr, bus.alu_s0, bus.halted};
        if (rs) begin
            chk("reset_ctl", 64'(dut_ctl), 64'd0);
            chk("reset_next", 64'(bus.next_state), 64'd0);
        end else begin
            e = peek();
            chk("state", 64'(bus.state), 64'(e.st));
            chk("ctl", 64'(dut_ctl), 64'(ctl(e)));
            chk("pc", 64'(bus.pc_out), 64'(m_pc));
            chk("ir", 64'(bus.ir_out), 64'(m_ir));
            chk("illegal", 64'(bus.illegal), 64'(m_ill));
            step(r, z);
            e = peek();
            chk("next_state", 64'(bus.next_state), 64'(e.st));
        end
        @(posedge clk);
        if (rs) model_reset();
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    endtask

    function automatic logic [15:0] rand_inst();
        int unsigned r = $urandom_range(0, 99);
        logic [3:0] op;
        logic [15:0] w = 16'($urandom);
        if (r < 2)      op = 4'(8 + $urandom_range(0, 7));
        else if (r < 4) op = 4'd5;
        else begin
            case ($urandom_range(0, 6))
                0: op = 4'd0; 1: op = 4'd1; 2: op = 4'd2; 3: op = 4'd3;
                4: op = 4'd4; 5: op = 4'd6; default: op = 4'd7;
            endcase
        end
        return {op, w[11:0]};
    endfunction

    initial begin
        bus.run = 1'b0; bus.rf_ra_zero = 1'b0; reset = 1'b1;
        model_reset();
        clear_mem();
        mem[0] = 16'h0000; mem[1] = 16'h2A05; mem[2] = 16'h3123; mem[3] = 16'h4A90;
        mem[4] = 16'h7410; mem[16] = 16'h6ABC; mem[17] = 16'h1C33;
        @(negedge clk);

        // directed program, JMPZ taken
        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        repeat (40) cycle(1'b1, 1'b1, 1'b0);
        // same program, JMPZ not taken, with a 5-cycle stall in FETCH
        repeat (2) cycle(1'b1, 1'b0, 1'b1);
        repeat (22) cycle(1'b1, 1'b0, 1'b0);
        while (peek().st != 4'd1) cycle(1'b1, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 1'b0);
        repeat (10) cycle(1'b1, 1'b0, 1'b0);

        // illegal opcode traps into HALT until reset
        mem[0] = 16'hF000;
        repeat (2) cycle(1'b1, 1'b0, 1'b1);
        repeat (12) cycle(1'b1, 1'b0, 1'b0);

        // reset asserted during LOAD_A
        mem[0] = 16'h2A05;
        repeat (2) cycle(1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        chk("in_load_a", 64'(bus.state), 64'd3);
        cycle(1'b1, 1'b0, 1'b1);
        repeat (6) cycle(1'b1, 1'b0, 1'b0);

        // all NOOPs: PC wraps from 0x7F to 0
        clear_mem();
        repeat (2) cycle(1'b1, 1'b0, 1'b1);
        repeat (270) cycle(1'b1, 1'b0, 1'b0);

        // random programs with random run, zero flag and occasional reset
        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < 128; i++) mem[i] = rand_inst();
            repeat (2) cycle(1'b1, 1'b0, 1'b1);
            for (int c = 0; c < 300; c++)
                cycle(($urandom_range(0, 9) < 8), 1'($urandom), ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
